// File: rtl/conv_ctrl_pkg.sv
// Shared types for the convolution loop controller: FSM states, latched job
// configuration and a rounding-up divide used for channel-group counts.
package conv_ctrl_pkg;

  localparam int CFG_DIM_W = 16;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DRAIN} fsm_state_t;

  typedef struct packed {
    logic [CFG_DIM_W-1:0] width;
    logic [CFG_DIM_W-1:0] height;
    logic [CFG_DIM_W-1:0] ch_in;
    logic [CFG_DIM_W-1:0] ch_out;
    logic [CFG_DIM_W-1:0] kernel;
  } cfg_t;

  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return (num + den - 32'd1) / den;
  endfunction

endpackage

// File: rtl/loop_counter_chain.sv
// Six cascaded wrap-around counters, index 0 innermost (k_h) to 5 outermost (x).
// A level steps on i_adv only when every inner level sits at its last value.
module loop_counter_chain
  import conv_ctrl_pkg::*;
#(
  parameter int DIM_W = CFG_DIM_W
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  i_clr,
  input  logic                  i_adv,
  input  logic [5:0][DIM_W-1:0] i_lim,
  output logic [5:0][DIM_W-1:0] o_cnt,
  output logic [3:0]            o_last,
  output logic                  o_last_overall
);

  logic [5:0][DIM_W-1:0] r_cnt;
  logic [5:0]            w_last;
  logic [5:0]            w_step;
  logic                  w_run;

  always_comb begin
    w_run  = i_adv;
    w_last = '0;
    w_step = '0;
    for (int i = 0; i < 6; i++) begin
      w_last[i] = (r_cnt[i] == i_lim[i] - DIM_W'(1));
      w_step[i] = w_run;
      w_run     = w_run && w_last[i];
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_step[i]) r_cnt[i] <= w_last[i] ? '0 : r_cnt[i] + DIM_W'(1);
      end
    end
  end

  assign o_cnt          = r_cnt;
  assign o_last         = w_last[3:0];
  assign o_last_overall = &w_last;

endmodule

// File: rtl/conv_controller_cfg.sv
// Convolution loop controller: latches a runtime config, issues one MAC per
// accepted a/b pair over x,y,ch_in,group,k_v,k_h, and drains the output pipe.
//
// state | meaning
// IDLE  | waiting for start; config checked here
// FETCH | ready for an operand pair
// MAC   | issuing a MAC, counters advance; back-to-back if a pair is accepted
// DRAIN | two cycles for the output pipe, then done
module conv_controller_cfg
  import conv_ctrl_pkg::*;
#(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int DIM_W              = CFG_DIM_W,
  parameter int MAX_KERNEL_SIZE    = 7,
  parameter int PAR_CH_OUT         = 4
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [DIM_W-1:0]              cfg_width,
  input  logic [DIM_W-1:0]              cfg_height,
  input  logic [DIM_W-1:0]              cfg_ch_in,
  input  logic [DIM_W-1:0]              cfg_ch_out,
  input  logic [DIM_W-1:0]              cfg_kernel,
  output logic                          running,
  output logic                          done,
  output logic                          cfg_error,
  input  logic                          a_valid,
  input  logic                          b_valid,
  output logic                          a_ready,
  output logic                          b_ready,
  output logic                          write_a,
  output logic                          write_b,
  output logic                          mac_valid,
  output logic                          mac_accumulate_internal,
  output logic                          mac_accumulate_with_0,
  output logic                          mem_we,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic                          output_valid,
  output logic [31:0]                   output_x,
  output logic [31:0]                   output_y,
  output logic [31:0]                   output_ch,
  output logic [PAR_CH_OUT-1:0]         output_lane_mask
);

  localparam int LV_KH = 0, LV_KV = 1, LV_G = 2, LV_CI = 3, LV_Y = 4, LV_X = 5;

  fsm_state_t r_state, w_state_nxt;
  cfg_t       r_cfg;
  logic [DIM_W-1:0] r_ng;
  logic       r_drain_wait, r_cfg_error;

  logic [5:0][DIM_W-1:0] w_lim, w_cnt;
  logic [3:0]  w_last;
  logic        w_last_overall, w_cfg_ok, w_latch, w_ready, w_mac, w_done;
  logic        w_kpos0, w_kend, w_ev_out;
  logic [31:0] w_ng_in, w_ch_base, w_rem;
  logic [PAR_CH_OUT-1:0] w_mask;

  logic                          r_mem_we, r_ev1, r_ev2;
  logic [LOG2_OF_MEM_HEIGHT-1:0] r_mem_waddr;
  logic [31:0]                   r_x1, r_y1, r_ch1, r_x2, r_y2, r_ch2;
  logic [PAR_CH_OUT-1:0]         r_mask1, r_mask2;

  assign w_ng_in  = ceil_div(32'(cfg_ch_out), 32'(PAR_CH_OUT));
  assign w_cfg_ok = (cfg_width != '0) && (cfg_height != '0) && (cfg_ch_in != '0) &&
                    (cfg_ch_out != '0) && (cfg_kernel != '0) &&
                    (cfg_kernel <= DIM_W'(MAX_KERNEL_SIZE)) &&
                    (64'(w_ng_in) <= (64'd1 << LOG2_OF_MEM_HEIGHT));
  assign w_latch  = (r_state == IDLE) && start && w_cfg_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_mac       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE:  if (start && w_cfg_ok) w_state_nxt = FETCH;
      FETCH: begin
        w_ready = 1'b1;
        if (a_valid && b_valid) w_state_nxt = MAC;
      end
      MAC: begin
        w_mac   = 1'b1;
        w_ready = !w_last_overall;
        if (w_last_overall)              w_state_nxt = DRAIN;
        else if (!(a_valid && b_valid))  w_state_nxt = FETCH;
      end
      DRAIN: if (r_drain_wait) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state      <= IDLE;
      r_drain_wait <= 1'b0;
      r_cfg_error  <= 1'b0;
      r_cfg        <= '0;
      r_ng         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_wait <= (r_state == DRAIN) && !r_drain_wait;
      r_cfg_error  <= (r_state == IDLE) && start && !w_cfg_ok;
      if (w_latch) begin
        r_cfg <= '{width: cfg_width, height: cfg_height, ch_in: cfg_ch_in,
                   ch_out: cfg_ch_out, kernel: cfg_kernel};
        r_ng  <= DIM_W'(w_ng_in);
      end
    end
  end

  always_comb begin
    w_lim        = '0;
    w_lim[LV_X]  = r_cfg.width;
    w_lim[LV_Y]  = r_cfg.height;
    w_lim[LV_CI] = r_cfg.ch_in;
    w_lim[LV_G]  = r_ng;
    w_lim[LV_KV] = r_cfg.kernel;
    w_lim[LV_KH] = r_cfg.kernel;
  end

  loop_counter_chain #(.DIM_W(DIM_W)) u_loops (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .i_clr          (w_latch),
    .i_adv          (w_mac),
    .i_lim          (w_lim),
    .o_cnt          (w_cnt),
    .o_last         (w_last),
    .o_last_overall (w_last_overall)
  );

  assign w_kpos0   = (w_cnt[LV_KV] == '0) && (w_cnt[LV_KH] == '0);
  assign w_kend    = w_mac && w_last[LV_KV] && w_last[LV_KH];
  assign w_ev_out  = w_kend && w_last[LV_CI];
  assign w_ch_base = 32'(w_cnt[LV_G]) * 32'(PAR_CH_OUT);
  assign w_rem     = 32'(r_cfg.ch_out) - w_ch_base;

  // Only the final group can be partial; its lane count is whatever remains.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAR_CH_OUT; i++) w_mask[i] = !w_last[LV_G] || (32'(i) < w_rem);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_mem_we <= 1'b0;  r_mem_waddr <= '0;
      r_ev1    <= 1'b0;  r_ev2       <= 1'b0;
      r_x1     <= '0;    r_y1        <= '0;  r_ch1 <= '0;  r_mask1 <= '0;
      r_x2     <= '0;    r_y2        <= '0;  r_ch2 <= '0;  r_mask2 <= '0;
    end else begin
      r_mem_we <= w_kend;
      if (w_kend) r_mem_waddr <= LOG2_OF_MEM_HEIGHT'(w_cnt[LV_G]);
      r_ev1 <= w_ev_out;
      r_ev2 <= r_ev1;
      if (w_ev_out) begin
        r_x1    <= 32'(w_cnt[LV_X]);
        r_y1    <= 32'(w_cnt[LV_Y]);
        r_ch1   <= w_ch_base;
        r_mask1 <= w_mask;
      end
      if (r_ev1) begin
        r_x2    <= r_x1;
        r_y2    <= r_y1;
        r_ch2   <= r_ch1;
        r_mask2 <= r_mask1;
      end
    end
  end

  assign running                 = (r_state != IDLE);
  assign done                    = w_done;
  assign cfg_error               = r_cfg_error;
  assign a_ready                 = w_ready;
  assign b_ready                 = w_ready;
  assign write_a                 = w_ready && a_valid && b_valid;
  assign write_b                 = w_ready && a_valid && b_valid;
  assign mac_valid               = w_mac;
  assign mac_accumulate_internal = w_mac && !w_kpos0;
  assign mac_accumulate_with_0   = w_mac && w_kpos0 && (w_cnt[LV_CI] == '0);
  assign mem_re                  = w_mac && w_kpos0;
  assign mem_read_addr           = LOG2_OF_MEM_HEIGHT'(w_cnt[LV_G]);
  assign mem_we                  = r_mem_we;
  assign mem_write_addr          = r_mem_waddr;
  assign output_valid            = r_ev2;
  assign output_x                = r_x2;
  assign output_y                = r_y2;
  assign output_ch               = r_ch2;
  assign output_lane_mask        = r_mask2;

endmodule

// File: tb/tb_conv_controller_cfg.sv
// Directed bench for conv_controller_cfg: a negedge monitor logs events with
// cycle stamps; each scenario task compares the log against hand-derived values.
module tb_conv_controller_cfg;

  logic        clk = 1'b0, arst_n_in = 1'b0, start = 1'b0;
  logic [15:0] cfg_width = '0, cfg_height = '0, cfg_ch_in = '0, cfg_ch_out = '0, cfg_kernel = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        running, done, cfg_error, a_ready, b_ready, write_a, write_b;
  logic        mac_valid, mac_accumulate_internal, mac_accumulate_with_0, mem_we, mem_re;
  logic [19:0] mem_write_addr, mem_read_addr;
  logic        output_valid;
  logic [31:0] output_x, output_y, output_ch;
  logic [3:0]  output_lane_mask;

  conv_controller_cfg dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_ch_in(cfg_ch_in),
    .cfg_ch_out(cfg_ch_out), .cfg_kernel(cfg_kernel),
    .running(running), .done(done), .cfg_error(cfg_error),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .write_a(write_a), .write_b(write_b), .mac_valid(mac_valid),
    .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch), .output_lane_mask(output_lane_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x, y, ch;
    logic [3:0]  mask;
  } out_t;

  logic [152:0] all_outs;
  assign all_outs = {running, done, cfg_error, a_ready, b_ready, write_a, write_b, mac_valid,
                     mac_accumulate_internal, mac_accumulate_with_0, mem_we, mem_re, output_valid,
                     mem_write_addr, mem_read_addr, output_x, output_y, output_ch, output_lane_mask};

  int checks = 0, errors = 0, cyc = 0;
  int mac_q[$], done_q[$], re_q[$], we_q[$], w0_q[$], ai_q[$], err_q[$], wa_q[$];
  int re_addr_q[$], we_addr_q[$];
  out_t out_q[$];

  always @(negedge clk) begin
    cyc++;
    if (mac_valid)               mac_q.push_back(cyc);
    if (done)                    done_q.push_back(cyc);
    if (cfg_error)               err_q.push_back(cyc);
    if (write_a)                 wa_q.push_back(cyc);
    if (mac_accumulate_with_0)   w0_q.push_back(cyc);
    if (mac_accumulate_internal) ai_q.push_back(cyc);
    if (mem_re) begin re_q.push_back(cyc); re_addr_q.push_back(int'(mem_read_addr)); end
    if (mem_we) begin we_q.push_back(cyc); we_addr_q.push_back(int'(mem_write_addr)); end
    if (output_valid) out_q.push_back({output_x, output_y, output_ch, output_lane_mask});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  // Start pulse for one cycle; cfg is scrambled afterwards so only latched values matter.
  task automatic start_job(input logic [15:0] w, h, ci, co, k);
    @(posedge clk); #1;
    cfg_width = w; cfg_height = h; cfg_ch_in = ci; cfg_ch_out = co; cfg_kernel = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_width = 16'hFFFF; cfg_height = 16'hFFFF; cfg_ch_in = 16'hFFFF;
    cfg_ch_out = 16'hFFFF; cfg_kernel = 16'hFFFF;
  endtask

  task automatic wait_done(input int base, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done_q.size() > base) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", all_outs); end
    @(posedge clk); #1 arst_n_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL idle_outs got %h exp 0", all_outs); end
  endtask

  task automatic test_back_to_back;
    int bm, bo, bd; bit got; out_t exp[4];
    exp[0] = {32'd0, 32'd0, 32'd0, 4'hF}; exp[1] = {32'd0, 32'd1, 32'd0, 4'hF};
    exp[2] = {32'd1, 32'd0, 32'd0, 4'hF}; exp[3] = {32'd1, 32'd1, 32'd0, 4'hF};
    bm = mac_q.size(); bo = out_q.size(); bd = done_q.size();
    a_valid = 1'b1; b_valid = 1'b1;
    start_job(16'd2, 16'd2, 16'd1, 16'd4, 16'd1);
    wait_done(bd, 100, got);
    checks++;
    if (!got) begin errors++; $display("FAIL b2b_done got none exp pulse"); end
    checks++;
    if (mac_q.size() - bm != 4) begin errors++; $display("FAIL b2b_macs got %0d exp 4", mac_q.size() - bm); end
    if (mac_q.size() - bm == 4 && got) begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (mac_q[bm+i] != mac_q[bm+i-1] + 1) begin
          errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, mac_q[bm+i], mac_q[bm+i-1] + 1);
        end
      end
      checks++;
      if (done_q[bd] != mac_q[bm+3] + 2) begin
        errors++; $display("FAIL b2b_done_lat got %0d exp %0d", done_q[bd], mac_q[bm+3] + 2);
      end
    end
    checks++;
    if (out_q.size() - bo != 4) begin errors++; $display("FAIL b2b_nout got %0d exp 4", out_q.size() - bo); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_q[bo+i] !== exp[i]) begin errors++; $display("FAIL b2b_out%0d got %h exp %h", i, out_q[bo+i], exp[i]); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_partial_group;
    int bo, bd, br, bw; bit got; out_t exp[4]; int ea[4];
    exp[0] = {32'd0, 32'd0, 32'd0, 4'hF}; exp[1] = {32'd0, 32'd0, 32'd4, 4'h3};
    exp[2] = {32'd0, 32'd1, 32'd0, 4'hF}; exp[3] = {32'd0, 32'd1, 32'd4, 4'h3};
    ea = '{0, 1, 0, 1};
    bo = out_q.size(); bd = done_q.size(); br = re_addr_q.size(); bw = we_addr_q.size();
    a_valid = 1'b1; b_valid = 1'b1;
    start_job(16'd1, 16'd2, 16'd1, 16'd6, 16'd1);
    wait_done(bd, 100, got);
    checks++;
    if (!got) begin errors++; $display("FAIL grp_done got none exp pulse"); end
    checks++;
    if (out_q.size() - bo != 4 || re_addr_q.size() - br != 4 || we_addr_q.size() - bw != 4) begin
      errors++; $display("FAIL grp_counts got out=%0d re=%0d we=%0d exp 4 each",
                         out_q.size() - bo, re_addr_q.size() - br, we_addr_q.size() - bw);
    end else for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_q[bo+i] !== exp[i] || re_addr_q[br+i] != ea[i] || we_addr_q[bw+i] != ea[i]) begin
        errors++; $display("FAIL grp_%0d got out=%h ra=%0d wa=%0d exp out=%h addr=%0d",
                           i, out_q[bo+i], re_addr_q[br+i], we_addr_q[bw+i], exp[i], ea[i]);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_kernel_pipe;
    int bm, bo, bd, br, bw, b0, bi; bit got;
    bm = mac_q.size(); bo = out_q.size(); bd = done_q.size();
    br = re_q.size(); bw = we_q.size(); b0 = w0_q.size(); bi = ai_q.size();
    a_valid = 1'b1; b_valid = 1'b1;
    start_job(16'd1, 16'd1, 16'd2, 16'd4, 16'd3);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1 b_valid = ~b_valid;
      @(negedge clk);
      if (done_q.size() > bd) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL kp_done got none exp pulse"); end
    checks++;
    if (mac_q.size() - bm != 18) begin errors++; $display("FAIL kp_macs got %0d exp 18", mac_q.size() - bm); end
    checks++;
    if (ai_q.size() - bi != 16) begin errors++; $display("FAIL kp_acc_int got %0d exp 16", ai_q.size() - bi); end
    if (mac_q.size() - bm == 18) begin
      checks++;
      if (re_q.size() - br != 2 || re_q[br] != mac_q[bm] || re_q[br+1] != mac_q[bm+9]) begin
        errors++; $display("FAIL kp_mem_re got n=%0d exp n=2 at %0d,%0d", re_q.size() - br, mac_q[bm], mac_q[bm+9]);
      end
      checks++;
      if (we_q.size() - bw != 2 || we_q[bw] != mac_q[bm+8] + 1 || we_q[bw+1] != mac_q[bm+17] + 1) begin
        errors++; $display("FAIL kp_mem_we got n=%0d exp n=2 at %0d,%0d", we_q.size() - bw, mac_q[bm+8] + 1, mac_q[bm+17] + 1);
      end
      checks++;
      if (w0_q.size() - b0 != 1 || w0_q[b0] != mac_q[bm]) begin
        errors++; $display("FAIL kp_acc0 got n=%0d exp n=1 at %0d", w0_q.size() - b0, mac_q[bm]);
      end
    end
    checks++;
    if (out_q.size() - bo != 1 || out_q[bo] !== {32'd0, 32'd0, 32'd0, 4'hF}) begin
      errors++; $display("FAIL kp_out got n=%0d exp n=1 (0,0,0,f)", out_q.size() - bo);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_cfg_error;
    logic [15:0] vec [5][5];
    bit          bad [5];
    int be, bm, bo, bd; bit got;
    vec[0] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0}; bad[0] = 1'b1;
    vec[1] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd8}; bad[1] = 1'b1;
    vec[2] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1}; bad[2] = 1'b1;
    vec[3] = '{16'd1, 16'd1, 16'd1, 16'd0, 16'd3}; bad[3] = 1'b1;
    vec[4] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd7}; bad[4] = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int v = 0; v < 5; v++) begin
      be = err_q.size(); bm = mac_q.size(); bo = out_q.size(); bd = done_q.size();
      start_job(vec[v][0], vec[v][1], vec[v][2], vec[v][3], vec[v][4]);
      @(negedge clk);
      checks++;
      if (running !== !bad[v]) begin errors++; $display("FAIL cfg%0d_running got %b exp %b", v, running, !bad[v]); end
      repeat (2) @(negedge clk);
      checks++;
      if (err_q.size() - be != (bad[v] ? 1 : 0)) begin
        errors++; $display("FAIL cfg%0d_err got %0d pulses exp %0d", v, err_q.size() - be, bad[v] ? 1 : 0);
      end
      if (!bad[v]) begin
        wait_done(bd, 200, got);
        checks++;
        if (!got || mac_q.size() - bm != 49 || out_q.size() - bo != 1 || out_q[bo].mask !== 4'b0001) begin
          errors++; $display("FAIL cfg%0d_job got done=%0b macs=%0d outs=%0d exp done=1 macs=49 outs=1 mask=0001",
                             v, got, mac_q.size() - bm, out_q.size() - bo);
        end
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_stall;
    int bm, bw, bd; bit got;
    bm = mac_q.size(); bw = wa_q.size(); bd = done_q.size();
    a_valid = 1'b1; b_valid = 1'b0;
    start_job(16'd1, 16'd1, 16'd1, 16'd4, 16'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (running !== 1'b1 || a_ready !== 1'b1 || mac_valid !== 1'b0 || write_a !== 1'b0) begin
        errors++; $display("FAIL stall%0d got run=%b rdy=%b mac=%b wa=%b exp 1 1 0 0", i, running, a_ready, mac_valid, write_a);
      end
    end
    @(posedge clk); #1 b_valid = 1'b1;
    wait_done(bd, 50, got);
    checks++;
    if (!got || mac_q.size() - bm != 1 || wa_q.size() - bw != 1) begin
      errors++; $display("FAIL stall_resume got done=%0b macs=%0d writes=%0d exp 1 1 1", got, mac_q.size() - bm, wa_q.size() - bw);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int bm, bo, bd; bit got;
    bm = mac_q.size(); bd = done_q.size();
    a_valid = 1'b1; b_valid = 1'b1;
    start_job(16'd1, 16'd1, 16'd1, 16'd1, 16'd7);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (mac_q.size() - bm >= 3) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rst_mid_reach got %0d macs exp 3", mac_q.size() - bm); end
    @(posedge clk); #1 arst_n_in = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL rst_mid_outs got %h exp 0", all_outs); end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 arst_n_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_q.size() != bd || running !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got dones=%0d run=%b exp 0 0", done_q.size() - bd, running);
    end
    bm = mac_q.size(); bo = out_q.size(); bd = done_q.size();
    start_job(16'd2, 16'd2, 16'd1, 16'd4, 16'd1);
    wait_done(bd, 100, got);
    checks++;
    if (!got || mac_q.size() - bm != 4 || out_q.size() - bo != 4) begin
      errors++; $display("FAIL rst_restart got done=%0b macs=%0d outs=%0d exp 1 4 4", got, mac_q.size() - bm, out_q.size() - bo);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial_group();
    test_kernel_pipe();
    test_cfg_error();
    test_stall();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_controller_cfg.md
Name: conv_controller_cfg

Overview:
Next-generation convolution loop controller. Loop dimensions are runtime-configurable and latched at start, and the block drives PAR_CH_OUT parallel MAC lanes, one output-channel group per operand pair. It sits between the host a/b handshake and the datapad/MAC/partial-sum memory. It adds a joint a/b handshake, back-to-back MAC issue, pipeline drain, a done pulse and config-error reporting.

Parameters:
LOG2_OF_MEM_HEIGHT, 20, partial-sum memory address width
DIM_W, 16, width of every cfg dimension field and loop counter
MAX_KERNEL_SIZE, 7, largest legal cfg_kernel
PAR_CH_OUT, 4, MAC lanes; output channels processed per group

Ports:
clk  in  1  clock
arst_n_in  in  1  reset, asynchronous, active-low
start  in  1  start request; sampled in IDLE only
cfg_width, cfg_height, cfg_ch_in, cfg_ch_out  in  DIM_W each  feature-map and channel dimensions
cfg_kernel  in  DIM_W  kernel size K (KxK)
running  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of job
cfg_error  out  1  one-cycle pulse when start is rejected
a_valid, b_valid  in  1  operand available
a_ready, b_ready  out  1  controller can accept operands
write_a, write_b  out  1  datapad write strobes
mac_valid, mac_accumulate_internal, mac_accumulate_with_0  out  1  MAC control
mem_we, mem_re  out  1  partial-sum memory enables
mem_write_addr, mem_read_addr  out  LOG2_OF_MEM_HEIGHT  channel-group index
output_valid  out  1  result strobe
output_x, output_y, output_ch  out  32  result coordinates; output_ch is the group base channel
output_lane_mask  out  PAR_CH_OUT  valid lanes of the emitted group

Behaviour:
- Reset: state IDLE. All counters, registers and outputs are 0.
- Reset mid-job: aborts immediately and returns to IDLE. No done pulse.
- Start in IDLE:
  - Config is valid when all dimensions are nonzero, 1 <= cfg_kernel <= MAX_KERNEL_SIZE, and NG = ceil(cfg_ch_out/PAR_CH_OUT) <= 2^LOG2_OF_MEM_HEIGHT.
  - Valid config: latch cfg into internal registers and go to FETCH.
  - Invalid config: pulse cfg_error, stay in IDLE.
  - start outside IDLE is ignored. cfg inputs may change freely after the latch.
- Loop order, outermost first: x, y, ch_in, g (group), k_v, k_h.
  - Each counter wraps to 0 at its latched limit minus 1.
  - A counter advances on mac_valid when all inner loops are at their last value.
- Handshake:
  - A pair is accepted when a_ready && a_valid && b_valid; write_a = write_b = accepted.
  - A lone a_valid or lone b_valid is never consumed.
- FETCH: a_ready = b_ready = 1. On accept, go to MAC.
- MAC:
  - mac_valid = 1 and counters advance this cycle; ready stays high.
  - On accept, stay in MAC (back-to-back issue, one MAC per cycle). Otherwise go to FETCH.
  - If the current MAC is the final overall MAC, go to DRAIN and deassert ready.
- DRAIN: wait 2 cycles for the output pipeline, then pulse done for 1 cycle and return to IDLE.
- MAC control:
  - mac_accumulate_internal = !(k_v==0 && k_h==0).
  - mac_accumulate_with_0 = (ch_in==0 && k_v==0 && k_h==0).
- Partial-sum memory:
  - mem_re = mac_valid && k_v==0 && k_h==0; mem_read_addr = g.
  - mem_we is registered from (mac_valid && last_k_v && last_k_h); mem_write_addr is g registered at the same event. Both land one cycle later.
- Outputs:
  - output_valid = event (mac_valid && last_ch_in && last_k_v && last_k_h) delayed 2 cycles.
  - output_x/y/ch/lane_mask are captured at the event; output_ch = g*PAR_CH_OUT.
  - lane_mask is all ones except on the last group, where it has (cfg_ch_out - g*PAR_CH_OUT) low bits set.
- Widths: counters are DIM_W bits, zero-extended to 32 on output_x/y/ch. The g*PAR_CH_OUT multiply is done in 32 bits.
- Simultaneous events: start during DRAIN is ignored. Pair-accept on the final MAC is not allowed, because ready is low in the final MAC cycle.

Decomposition:
- Package conv_ctrl_pkg holds:
  - fsm_state_t enum {IDLE, FETCH, MAC, DRAIN}
  - cfg_t struct (the five dimension fields)
  - function ceil_div
- One sub-module, loop_counter_chain: six cascaded counters with per-level limits and an advance input. It outputs the counter values, the last_* flags and last_overall.

Test Plan:
- cfg 2x2, ch_in=1, ch_out=4, K=1, PAR=4; a/b valid held high -> 4 MACs on consecutive cycles; output_valid 4 times at x,y=(0,0),(0,1),(1,0),(1,1), ch=0, mask=4'b1111; done 2 cycles after the last mac_valid.
- cfg ch_out=6, PAR=4 -> per pixel, groups at output_ch=0 (mask 1111) and output_ch=4 (mask 0011).
- cfg K=3, ch_in=2, 1x1 map; b_valid toggling every other cycle -> 18 MACs; mem_re on k_v=k_h=0; mem_we 1 cycle after each (2,2); mac_accumulate_with_0 only while ch_in=0.
- start with cfg_kernel=0 or 8 -> cfg_error pulse, running stays 0; start with cfg_kernel=7 accepted.
- a_valid=1, b_valid=0 for 10 cycles -> no write_a, no mac_valid, stays in FETCH.
- arst_n_in low mid-MAC -> all outputs 0, IDLE, no done; a restart completes normally.
